// File: rtl/prach_sched.sv
// prach_sched - PRACH capture job scheduler.
//
// Holds one pending capture request per (CC, antenna) slot. Requests arrive as
// single-cycle C-Plane pulses. The block tracks the frame sample position and
// marks a slot due when that position reaches the slot's start time. Due slots
// are round-robin arbitrated onto one valid/ready job port that feeds the
// shared PRACH extraction engine.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   c_valid[cc][ant]      request pulse per channel (ch = cc*NUM_ANT + ant)
//   c_frequency_offset, c_time_offset, c_num_symbol, c_header
//                         request payload shared by all pulsed channels
//   frame_sync            frame boundary pulse; clears time_cnt
//   sample_tick           one strobe per sample; advances time_cnt
//   time_cnt              current frame sample position
//   job_valid/job_ready   job handshake towards the engine
//   job_cc, job_ant, job_frequency_offset, job_num_symbol, job_header
//                         payload of the offered job
//   overflow              one-cycle pulse when a pending request is overwritten
//   grant_count, overflow_count
//                         saturating statistics counters
//
// Optional build macro: PRACH_SCHED_STATS_EN enables grant_count and
// overflow_count. Without it both ports are tied to 0.

module prach_sched #(
    parameter int unsigned NUM_CC    = 3,
    parameter int unsigned NUM_ANT   = 8,
    parameter int unsigned FRAME_LEN = 614400
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CC-1:0][NUM_ANT-1:0]  c_valid,
    input  logic [16:0]                     c_frequency_offset,
    input  logic [19:0]                     c_time_offset,
    input  logic [3:0]                      c_num_symbol,
    input  logic [119:0]                    c_header,
    input  logic                            frame_sync,
    input  logic                            sample_tick,
    output logic [19:0]                     time_cnt,
    output logic                            job_valid,
    input  logic                            job_ready,
    output logic [1:0]                      job_cc,
    output logic [2:0]                      job_ant,
    output logic [16:0]                     job_frequency_offset,
    output logic [3:0]                      job_num_symbol,
    output logic [119:0]                    job_header,
    output logic                            overflow,
    output logic [15:0]                     grant_count,
    output logic [15:0]                     overflow_count
);

    localparam int unsigned NUM_CH    = NUM_CC * NUM_ANT;
    localparam int unsigned CH_W      = $clog2(NUM_CH);
    localparam logic [19:0] TIME_LAST = 20'(FRAME_LEN - 1);

    // Slot table
    logic [16:0]        r_freq  [NUM_CH];
    logic [19:0]        r_start [NUM_CH];
    logic [3:0]         r_nsym  [NUM_CH];
    logic [119:0]       r_hdr   [NUM_CH];
    logic [NUM_CH-1:0]  r_pend;
    logic [NUM_CH-1:0]  r_due;

    logic [19:0]        r_time_cnt;
    logic [CH_W-1:0]    r_ptr;
    logic               r_job_valid;
    logic [1:0]         r_job_cc;
    logic [2:0]         r_job_ant;
    logic [16:0]        r_job_freq;
    logic [3:0]         r_job_nsym;
    logic [119:0]       r_job_hdr;
    logic               r_overflow;

    logic [NUM_CH-1:0]  w_cv;
    logic [NUM_CH-1:0]  w_hit;
    logic [NUM_CH-1:0]  w_grant_oh;
    logic               w_arb_en;
    logic               w_found;
    logic               w_grant;
    logic [CH_W-1:0]    w_sel;
    logic [1:0]         w_sel_cc;
    logic [2:0]         w_sel_ant;
    logic               w_ovf;

    assign w_cv     = c_valid;
    assign w_arb_en = !r_job_valid || job_ready;
    assign w_grant  = w_arb_en && w_found;
    assign w_sel_cc  = 2'(32'(w_sel) / NUM_ANT);
    assign w_sel_ant = 3'(32'(w_sel) % NUM_ANT);
    // A load colliding with a grant of the same slot is not an overwrite:
    // the grant consumes the old request.
    assign w_ovf    = |(w_cv & r_pend & ~w_grant_oh);

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        int unsigned v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            v_idx = (32'(r_ptr) + k) % NUM_CH;
            if (!w_found && r_due[CH_W'(v_idx)]) begin
                w_found = 1'b1;
                w_sel   = CH_W'(v_idx);
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        if (w_grant) begin
            w_grant_oh[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_hit = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_hit[i] = r_pend[i] && !r_due[i] && (r_start[i] == r_time_cnt);
        end
    end

    // Frame sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time_cnt <= '0;
        end else if (frame_sync) begin
            r_time_cnt <= '0;
        end else if (sample_tick) begin
            r_time_cnt <= (r_time_cnt == TIME_LAST) ? '0 : r_time_cnt + 20'd1;
        end
    end

    // Slot payload needs no reset; validity is carried by r_pend.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_cv[i]) begin
                r_freq[i]  <= c_frequency_offset;
                r_start[i] <= c_time_offset;
                r_nsym[i]  <= c_num_symbol;
                r_hdr[i]   <= c_header;
            end
        end
    end

    // Slot flags: a load wins over a same-cycle grant of that slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_due  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_cv[i]) begin
                    r_pend[i] <= 1'b1;
                    r_due[i]  <= 1'b0;
                end else if (w_grant_oh[i]) begin
                    r_pend[i] <= 1'b0;
                    r_due[i]  <= 1'b0;
                end else if (w_hit[i]) begin
                    r_due[i]  <= 1'b1;
                end
            end
        end
    end

    // Job output registers and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_job_valid <= 1'b0;
            r_job_cc    <= '0;
            r_job_ant   <= '0;
            r_job_freq  <= '0;
            r_job_nsym  <= '0;
            r_job_hdr   <= '0;
            r_ptr       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= w_ovf;
            if (w_grant) begin
                r_job_valid <= 1'b1;
                r_job_cc    <= w_sel_cc;
                r_job_ant   <= w_sel_ant;
                r_job_freq  <= r_freq[w_sel];
                r_job_nsym  <= r_nsym[w_sel];
                r_job_hdr   <= r_hdr[w_sel];
                r_ptr       <= w_sel;
            end else if (r_job_valid && job_ready) begin
                r_job_valid <= 1'b0;
            end
        end
    end

`ifdef PRACH_SCHED_STATS_EN
    logic [15:0] r_grant_cnt;
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            if (r_job_valid && job_ready && (r_grant_cnt != '1)) begin
                r_grant_cnt <= r_grant_cnt + 16'd1;
            end
            if (r_overflow && (r_ovf_cnt != '1)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign grant_count    = r_grant_cnt;
    assign overflow_count = r_ovf_cnt;
`else
    assign grant_count    = '0;
    assign overflow_count = '0;
`endif

    assign time_cnt             = r_time_cnt;
    assign job_valid            = r_job_valid;
    assign job_cc               = r_job_cc;
    assign job_ant              = r_job_ant;
    assign job_frequency_offset = r_job_freq;
    assign job_num_symbol       = r_job_nsym;
    assign job_header           = r_job_hdr;
    assign overflow             = r_overflow;

endmodule

// File: doc/prach_sched.md
Name: prach_sched

Overview:
- Schedules PRACH capture jobs between the C-Plane decoder and the shared PRACH extraction/packetizer engine.
- Holds one pending request per (CC, antenna), 3x8 = 24 slots, loaded from decoded C-Plane pulses.
- Tracks the frame sample position, marks each slot due when its start time is reached, and round-robin arbitrates due slots onto a single valid/ready job port.

Parameters:
- NUM_CC, 3, number of component carriers.
- NUM_ANT, 8, antennas per CC; NUM_CH = NUM_CC*NUM_ANT.
- FRAME_LEN, 614400, samples per 10 ms frame at 61.44 Msps; time counter wraps at FRAME_LEN-1.

Ports:
- clk  in  1  clk_eth_xran domain clock
- rst_n  in  1  asynchronous active-low reset
- c_valid  in  [NUM_CC][NUM_ANT]  one-cycle request pulse per channel
- c_frequency_offset  in  17  PRACH frequency offset for the request
- c_time_offset  in  20  start sample within the frame
- c_num_symbol  in  4  PRACH symbol count
- c_header  in  120  U-Plane header for the request
- frame_sync  in  1  pulse; frame boundary
- sample_tick  in  1  one-cycle strobe per sample
- time_cnt  out  20  current frame sample position
- job_valid  out  1  job offered to the engine
- job_ready  in  1  engine accepts the job
- job_cc  out  2  CC index of the job
- job_ant  out  3  antenna index of the job
- job_frequency_offset  out  17  stored frequency offset
- job_num_symbol  out  4  stored symbol count
- job_header  out  120  stored header
- overflow  out  1  one-cycle pulse; a pending request was overwritten
- grant_count  out  16  see Optional Feature
- overflow_count  out  16  see Optional Feature

Behaviour:
- Reset: all outputs, time_cnt, slot pending/due flags, and round-robin pointer are 0 (pointer at channel 0).
- Time counter:
  - frame_sync forces time_cnt to 0 next cycle, with priority over sample_tick.
  - Otherwise each sample_tick increments time_cnt; FRAME_LEN-1 wraps to 0.
- Slot load:
  - c_valid[cc][ant] writes that slot's offset, time, symbols and header on the next edge, and sets pending=1, due=0.
  - If several bits are set in one cycle, all those slots load the same data.
  - Channel index ch = cc*NUM_ANT + ant.
- Overwrite: if the slot was already pending (due or not), it is overwritten, and overflow pulses 1 cycle.
- Due detection: pending && !due && time_cnt == stored time sets due on the next edge.
  - A slot loaded with time equal to the current time_cnt becomes due one cycle after loading.
  - A slot whose time has already passed waits for the wrap.
- Arbitration:
  - Runs when job_valid==0, or when job_valid && job_ready.
  - Selects the first due slot searching ch = ptr+1 .. ptr+NUM_CH (mod NUM_CH).
  - On a selection:
    - Copies the slot into the job_* registers and sets job_valid=1 next cycle.
    - Clears the slot's pending and due flags and sets ptr=ch.
  - If nothing is due after a handshake, job_valid drops to 0.
  - Back-to-back jobs are allowed: handshake and next grant occur in the same cycle.
- Handshake: job_* are stable while job_valid && !job_ready. The job_* registers are independent of the table, so a new c_valid to the in-flight channel loads the slot normally without overflow.
- Simultaneous load and grant on the same slot: the grant takes the old contents; the load wins the table, leaving pending=1, due=0, and no overflow.
- frame_sync does not clear pending slots or the in-flight job.
- Reset mid-job: job_valid drops asynchronously and the job is lost.

Optional Feature:
- Macro: PRACH_SCHED_STATS_EN.
- Defined:
  - grant_count increments on each job handshake.
  - overflow_count increments on each overflow pulse.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: both ports are driven constant 0, and no counter logic is present.

Test Plan:
- Load sequence:
  - Stimulus: c_valid[0][0] with time 100, then frame_sync, then 100 sample_ticks, job_ready=1.
  - Response: job_valid rises 2 cycles after time_cnt==100; job_cc=0, job_ant=0; header and offset match; one job only.
- Round-robin:
  - Stimulus: slots [0][1], [1][3], [2][7] all at time 50, job_ready=1.
  - Response: jobs in order ch 1, 11, 23 on consecutive cycles; the next due ch 1 after a grant of 23 comes out first.
- Backpressure:
  - Stimulus: job_ready=0 for 10 cycles with two due slots.
  - Response: job_* constant for 10 cycles; the second job appears the cycle after job_ready=1.
- Overwrite:
  - Stimulus: c_valid[1][2] twice before due, second with time 300.
  - Response: overflow pulses once; one job with time/header of the second request; overflow_count=1 when PRACH_SCHED_STATS_EN.
- Wrap and late time:
  - Stimulus: load time 10 while time_cnt=500; run ticks through 614399->0.
  - Response: job issued only after wrap at time_cnt==10.
- Reset:
  - Stimulus: assert rst_n=0 while job_valid=1 and 3 slots pending.
  - Response: all outputs immediately 0; no jobs after release without new c_valid.
